// File: rtl/defuse_array_scanner.sv
// -----------------------------------------------------------------------------
// defuse_array_scanner
//
// Read-only sweeper for the minesweeper board. It walks the level-selected
// defuse map and the matching mine map one field per clock, accumulates the
// number of defused fields, the number of mines and whether any mine was
// defused, and publishes the totals once per completed sweep.
//
// Ports
//   clk               system clock
//   rst               synchronous, active-high reset
//   level             0 = no game, 1 = easy, 2 = medium, 3 = hard
//   defuse_arr_*      defused map per level, indexed [y][x], 1 = defused
//   mine_arr_*        mine map per level, indexed [y][x], 1 = mine
//   scan_x / scan_y   field being sampled this cycle
//   defused_count     defused fields found in the last completed sweep
//   sweep_done        one-cycle pulse marking a fresh set of results
//   win               last sweep: all non-mine fields defused, no mine defused
//   lose              last sweep: some field had both defuse and mine set
//
// Timing
//   A sweep is N*N SCAN cycles followed by one LATCH cycle, so sweep_done
//   pulses every N*N+1 cycles. The final field is folded into the results on
//   the edge that enters LATCH, so defused_count/win/lose already carry the new
//   values during the sweep_done cycle and hold them until the next pulse.
// -----------------------------------------------------------------------------
module defuse_array_scanner #(
   parameter int EASY_SIZE   = 8,
   parameter int MEDIUM_SIZE = 10,
   parameter int HARD_SIZE   = 16
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic [1:0]                                level,
   input  logic [EASY_SIZE-1:0][EASY_SIZE-1:0]       defuse_arr_easy,
   input  logic [MEDIUM_SIZE-1:0][MEDIUM_SIZE-1:0]   defuse_arr_medium,
   input  logic [HARD_SIZE-1:0][HARD_SIZE-1:0]       defuse_arr_hard,
   input  logic [EASY_SIZE-1:0][EASY_SIZE-1:0]       mine_arr_easy,
   input  logic [MEDIUM_SIZE-1:0][MEDIUM_SIZE-1:0]   mine_arr_medium,
   input  logic [HARD_SIZE-1:0][HARD_SIZE-1:0]       mine_arr_hard,
   output logic [4:0]                                scan_x,
   output logic [4:0]                                scan_y,
   output logic [8:0]                                defused_count,
   output logic                                      sweep_done,
   output logic                                      win,
   output logic                                      lose
);

   // Index widths needed to address each board edge.
   localparam int EW = $clog2(EASY_SIZE);
   localparam int MW = $clog2(MEDIUM_SIZE);
   localparam int HW = $clog2(HARD_SIZE);

   // Last coordinate and field total per level.
   localparam logic [4:0] EASY_LAST     = 5'(EASY_SIZE - 1);
   localparam logic [4:0] MEDIUM_LAST   = 5'(MEDIUM_SIZE - 1);
   localparam logic [4:0] HARD_LAST     = 5'(HARD_SIZE - 1);
   localparam logic [8:0] EASY_FIELDS   = 9'(EASY_SIZE * EASY_SIZE);
   localparam logic [8:0] MEDIUM_FIELDS = 9'(MEDIUM_SIZE * MEDIUM_SIZE);
   localparam logic [8:0] HARD_FIELDS   = 9'(HARD_SIZE * HARD_SIZE);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      LATCH = 2'd2
   } state_t;

   state_t     state;
   logic [1:0] sweep_level;   // level the running sweep was started with
   logic [8:0] acc_def;
   logic [8:0] acc_mine;
   logic       acc_hit;

   // Combinational view of the field under the scan pointer.
   logic       cur_def;
   logic       cur_mine;
   logic [4:0] last_idx;
   logic [8:0] field_total;
   logic [8:0] def_sum;
   logic [8:0] mine_sum;
   logic       hit_sum;
   logic [9:0] cover_sum;
   logic       last_field;
   logic       level_changed;

   // NOTE: every signal written here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      cur_def     = 1'b0;
      cur_mine    = 1'b0;
      last_idx    = EASY_LAST;
      field_total = EASY_FIELDS;
      case (sweep_level)
         2'd1: begin
            cur_def     = defuse_arr_easy[scan_y[EW-1:0]][scan_x[EW-1:0]];
            cur_mine    = mine_arr_easy[scan_y[EW-1:0]][scan_x[EW-1:0]];
            last_idx    = EASY_LAST;
            field_total = EASY_FIELDS;
         end
         2'd2: begin
            cur_def     = defuse_arr_medium[scan_y[MW-1:0]][scan_x[MW-1:0]];
            cur_mine    = mine_arr_medium[scan_y[MW-1:0]][scan_x[MW-1:0]];
            last_idx    = MEDIUM_LAST;
            field_total = MEDIUM_FIELDS;
         end
         2'd3: begin
            cur_def     = defuse_arr_hard[scan_y[HW-1:0]][scan_x[HW-1:0]];
            cur_mine    = mine_arr_hard[scan_y[HW-1:0]][scan_x[HW-1:0]];
            last_idx    = HARD_LAST;
            field_total = HARD_FIELDS;
         end
         default: ;
      endcase

      // Running totals including the field sampled this cycle.
      def_sum       = acc_def + {8'd0, cur_def};
      mine_sum      = acc_mine + {8'd0, cur_mine};
      hit_sum       = acc_hit | (cur_def & cur_mine);
      // One bit wider: with a defused mine the two counts can overlap.
      cover_sum     = {1'b0, def_sum} + {1'b0, mine_sum};
      last_field    = (scan_x == last_idx) && (scan_y == last_idx);
      level_changed = (level != sweep_level);
   end

   // NOTE: state is updated with non-blocking assignments only, so every
   // register sees the pre-edge values of the others regardless of order.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: reset is synchronous, so it only takes effect on a clock edge.
         state         <= IDLE;
         sweep_level   <= 2'd0;
         scan_x        <= 5'd0;
         scan_y        <= 5'd0;
         acc_def       <= 9'd0;
         acc_mine      <= 9'd0;
         acc_hit       <= 1'b0;
         defused_count <= 9'd0;
         sweep_done    <= 1'b0;
         win           <= 1'b0;
         lose          <= 1'b0;
      end else begin
         sweep_done <= 1'b0;
         case (state)
            IDLE: begin
               scan_x      <= 5'd0;
               scan_y      <= 5'd0;
               acc_def     <= 9'd0;
               acc_mine    <= 9'd0;
               acc_hit     <= 1'b0;
               sweep_level <= level;
               if (level != 2'd0) begin
                  state <= SCAN;
               end
            end

            SCAN: begin
               if (level_changed) begin
                  // Partial sweep is thrown away; published results hold.
                  scan_x      <= 5'd0;
                  scan_y      <= 5'd0;
                  acc_def     <= 9'd0;
                  acc_mine    <= 9'd0;
                  acc_hit     <= 1'b0;
                  sweep_level <= level;
                  state       <= (level == 2'd0) ? IDLE : SCAN;
               end else if (last_field) begin
                  // Last field: publish totals together with the pulse.
                  defused_count <= def_sum;
                  lose          <= hit_sum;
                  win           <= !hit_sum && (cover_sum == {1'b0, field_total});
                  sweep_done    <= 1'b1;
                  scan_x        <= 5'd0;
                  scan_y        <= 5'd0;
                  acc_def       <= 9'd0;
                  acc_mine      <= 9'd0;
                  acc_hit       <= 1'b0;
                  state         <= LATCH;
               end else begin
                  acc_def  <= def_sum;
                  acc_mine <= mine_sum;
                  acc_hit  <= hit_sum;
                  if (scan_x == last_idx) begin
                     scan_x <= 5'd0;
                     scan_y <= scan_y + 5'd1;
                  end else begin
                     scan_x <= scan_x + 5'd1;
                  end
               end
            end

            LATCH: begin
               scan_x      <= 5'd0;
               scan_y      <= 5'd0;
               acc_def     <= 9'd0;
               acc_mine    <= 9'd0;
               acc_hit     <= 1'b0;
               sweep_level <= level;
               state       <= (level == 2'd0) ? IDLE : SCAN;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_defuse_array_scanner.sv
// -----------------------------------------------------------------------------
// tb_defuse_array_scanner
//
// Directed bench for defuse_array_scanner. Each step drives the level and the
// board maps, waits for sweep_done with a bounded cycle budget and compares
// the outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_defuse_array_scanner;

   logic             clk = 1'b0;
   logic             rst;
   logic [1:0]       level;
   logic [7:0][7:0]   de_e, me_e;
   logic [9:0][9:0]   de_m, me_m;
   logic [15:0][15:0] de_h, me_h;
   logic [4:0]       scan_x, scan_y;
   logic [8:0]       defused_count;
   logic             sweep_done, win, lose;

   int errors = 0;
   int checks = 0;
   int cycles;
   bit held;

   always #5 clk = ~clk;

   defuse_array_scanner dut (
      .clk               (clk),
      .rst               (rst),
      .level             (level),
      .defuse_arr_easy   (de_e),
      .defuse_arr_medium (de_m),
      .defuse_arr_hard   (de_h),
      .mine_arr_easy     (me_e),
      .mine_arr_medium   (me_m),
      .mine_arr_hard     (me_h),
      .scan_x            (scan_x),
      .scan_y            (scan_y),
      .defused_count     (defused_count),
      .sweep_done        (sweep_done),
      .win               (win),
      .lose              (lose)
   );

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Advance until sweep_done is seen; cycles is the edge count at which it
   // appeared (-1 on timeout). held reports whether the published results
   // stayed constant before the pulse.
   task automatic wait_done(input int limit, output int cyc, output bit hold);
      logic [8:0] c0;
      logic       w0, l0;
      c0   = defused_count;
      w0   = win;
      l0   = lose;
      hold = 1'b1;
      cyc  = -1;
      for (int i = 1; i <= limit; i++) begin
         @(posedge clk);
         #1;
         if (sweep_done) begin
            cyc = i;
            return;
         end
         if (defused_count !== c0 || win !== w0 || lose !== l0) hold = 1'b0;
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_scan_x"}, 32'(scan_x), 32'd0);
      check({tag, "_scan_y"}, 32'(scan_y), 32'd0);
      check({tag, "_count"},  32'(defused_count), 32'd0);
      check({tag, "_done"},   32'(sweep_done), 32'd0);
      check({tag, "_win"},    32'(win), 32'd0);
      check({tag, "_lose"},   32'(lose), 32'd0);
   endtask

   initial begin
      rst   = 1'b1;
      level = 2'd0;
      de_e  = '0; me_e = '0;
      de_m  = '0; me_m = '0;
      de_h  = '0; me_h = '0;

      // Step 1: reset state.
      repeat (2) @(posedge clk);
      #1;
      check_outputs_zero("reset");

      // Step 2: easy, empty board; pulse 65 edges after leaving IDLE.
      rst   = 1'b0;
      level = 2'd1;
      wait_done(200, cycles, held);
      check("easy_empty_latency", 32'(cycles), 32'd65);
      check("easy_empty_count", 32'(defused_count), 32'd0);
      check("easy_empty_win", 32'(win), 32'd0);
      check("easy_empty_lose", 32'(lose), 32'd0);
      @(posedge clk);
      #1;
      check("pulse_width", 32'(sweep_done), 32'd0);
      check("easy_empty_count_hold", 32'(defused_count), 32'd0);

      // Step 3: easy win board, mines at [0][0] and [7][7], 62 defused.
      de_e       = '1;
      de_e[0][0] = 1'b0;
      de_e[7][7] = 1'b0;
      me_e[0][0] = 1'b1;
      me_e[7][7] = 1'b1;
      wait_done(200, cycles, held);        // sweep straddling the map change
      wait_done(200, cycles, held);
      check("easy_period", 32'(cycles), 32'd65);
      check("easy_win_count", 32'(defused_count), 32'd62);
      check("easy_win_win", 32'(win), 32'd1);
      check("easy_win_lose", 32'(lose), 32'd0);

      // Step 4: hard board, defused mine at [5][9] plus 10 plain defuses.
      me_h[5][9] = 1'b1;
      de_h[5][9] = 1'b1;
      for (int x = 0; x < 10; x++) de_h[0][x] = 1'b1;
      level = 2'd3;
      wait_done(600, cycles, held);
      check("hard_first_latency", 32'(cycles), 32'd257);
      check("hard_count", 32'(defused_count), 32'd11);
      check("hard_lose", 32'(lose), 32'd1);
      check("hard_win", 32'(win), 32'd0);
      wait_done(600, cycles, held);
      check("hard_period", 32'(cycles), 32'd257);
      check("hard_count_again", 32'(defused_count), 32'd11);

      // Step 5: medium, fully defused and mine-free; scan order check.
      de_m  = '1;
      level = 2'd2;
      wait_done(300, cycles, held);
      check("medium_latency", 32'(cycles), 32'd101);
      check("medium_count", 32'(defused_count), 32'd100);
      check("medium_win", 32'(win), 32'd1);
      check("medium_lose", 32'(lose), 32'd0);
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("scan_x_%0d", i), 32'(scan_x), 32'(i % 10));
         check($sformatf("scan_y_%0d", i), 32'(scan_y), 32'(i / 10));
      end
      @(posedge clk);
      #1;
      check("done_after_9_9", 32'(sweep_done), 32'd1);

      // Step 6: switch medium -> hard 50 cycles into a sweep.
      repeat (50) begin
         @(posedge clk);
         #1;
      end
      level = 2'd3;
      wait_done(600, cycles, held);
      check("switch_restart_latency", 32'(cycles), 32'd257);
      check("switch_outputs_held", 32'(held), 32'd1);
      check("switch_hard_count", 32'(defused_count), 32'd11);
      check("switch_hard_lose", 32'(lose), 32'd1);
      check("switch_hard_win", 32'(win), 32'd0);

      // Step 7: reach win on easy, then reset mid-sweep.
      level = 2'd1;
      wait_done(200, cycles, held);
      check("pre_reset_win", 32'(win), 32'd1);
      check("pre_reset_count", 32'(defused_count), 32'd62);
      repeat (20) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_outputs_zero("mid_reset");
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("resume_x0", 32'(scan_x), 32'd0);
      check("resume_y0", 32'(scan_y), 32'd0);
      @(posedge clk);
      #1;
      check("resume_x1", 32'(scan_x), 32'd1);
      wait_done(200, cycles, held);
      check("post_reset_latency", 32'(cycles), 32'd63);
      check("post_reset_win", 32'(win), 32'd1);
      check("post_reset_count", 32'(defused_count), 32'd62);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/defuse_array_scanner.md
Name: defuse_array_scanner

Overview:
- Reader on the far end of the defuse-array path.
- Continuously sweeps the level-selected defuse array together with the matching mine array, one field per clock.
- From each completed sweep it derives the defused-field count and the win/lose status.
- Results feed the game-state FSM and the counter display; the block never writes the arrays.

Parameters:
- EASY_SIZE, 8, board edge for level 1
- MEDIUM_SIZE, 10, board edge for level 2
- HARD_SIZE, 16, board edge for level 3

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- level  in  2  0 = no game, 1 = easy, 2 = medium, 3 = hard
- defuse_arr_easy  in  [7:0][7:0]  defused map, indexed [y][x], '1 = defused
- defuse_arr_medium  in  [9:0][9:0]  as above
- defuse_arr_hard  in  [15:0][15:0]  as above
- mine_arr_easy  in  [7:0][7:0]  mine map, '1 = mine
- mine_arr_medium  in  [9:0][9:0]  as above
- mine_arr_hard  in  [15:0][15:0]  as above
- scan_x  out  5  column currently sampled
- scan_y  out  5  row currently sampled
- defused_count  out  9  defused fields found in the last completed sweep (0..256)
- sweep_done  out  1  one-cycle pulse when the registered results update
- win  out  1  last sweep: every non-mine field defused and no mine defused
- lose  out  1  last sweep: at least one field with both defuse and mine set

Behaviour:
- Reset: scan_x = scan_y = 0, defused_count = 0, sweep_done = 0, win = 0, lose = 0, accumulators cleared, FSM state IDLE.
- N = selected edge size: 8, 10 or 16 for level 1, 2, 3.
- FSM states:
  - IDLE: level == 0; outputs hold their values; accumulators cleared; x = y = 0. Moves to SCAN when level != 0.
  - SCAN: each cycle, sample defuse[y][x] and mine[y][x] at the current scan_x/scan_y. Then:
    - add 1 to acc_def if defuse is set;
    - add 1 to acc_mine if mine is set;
    - set acc_hit if both are set.
    - Advance x; at x == N-1, wrap x to 0 and increment y.
    - At x == N-1 and y == N-1 (last field), move to LATCH; that field is accumulated in the same cycle.
  - LATCH (1 cycle):
    - defused_count <= acc_def.
    - lose <= acc_hit.
    - win <= !acc_hit && (acc_def + acc_mine == N*N).
    - sweep_done = 1.
    - Clear accumulators and x/y, then return to SCAN (or to IDLE if level == 0).
- Sweep period: N*N + 1 cycles, i.e. 65 / 101 / 257 for easy / medium / hard.
- Arithmetic: accumulators are 9 bits; N*N is computed as a 9-bit constant per level; no overflow is possible (max 256).
- Level change mid-sweep (level differs from the value latched at sweep start): discard the partial sweep, clear accumulators and x/y, restart SCAN next cycle; no sweep_done; outputs hold.
- Level going to 0 mid-sweep: go to IDLE; outputs hold.
- The arrays may change during a sweep. Each field is sampled exactly once per sweep; no snapshot is taken.
- win and lose are never both 1.
- win = 1 with zero mines is legal (all N*N fields defused).

Test Plan:
- Reset, then level = 1 with all-zero arrays → first sweep_done 65 cycles after leaving IDLE; defused_count = 0, win = 0, lose = 0.
- Level = 1, mines at [0][0] and [7][7], all other 62 fields defused → defused_count = 62, win = 1, lose = 0.
- Level = 3, mine at [5][9] and defuse at [5][9] plus 10 others → defused_count = 11, lose = 1, win = 0; period 257 cycles between sweep_done pulses.
- Level = 2: check the scan_x/scan_y sequence 0..9 per row with wrap at x = 9; the last sample is (9,9) immediately before the sweep_done cycle.
- Switch level 2 → 3 at cycle 50 of a sweep → no sweep_done for the partial sweep; next sweep_done 257 cycles after restart; previous outputs held until then.
- Assert rst mid-sweep with results previously win = 1 → all outputs 0 the next cycle; scan resumes from (0,0).
